// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent push-button debouncers on a single clock.
// Each channel: 2-flop synchronizer -> 4-state debounce FSM (ZERO, WAIT1,
// ONE, WAIT0) with a down-counter -> registered level and edge ticks.
// Optional auto-repeat (repeat_tick while a channel is held in ONE) is
// compiled only when the macro DEBOUNCE_BANK_REPEAT_EN is defined; otherwise
// repeat_tick is tied low and no hold/repeat counters exist.
// Reset is synchronous and active-high.

module debounce_bank #(
  parameter int N_CH             = 4,
  parameter int CLK_FREQ         = 27_000_000,
  parameter int DEBOUNCE_TIME_MS = 20,
  parameter int HOLD_MS          = 500,
  parameter int REPEAT_MS        = 100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_level,
  output logic [N_CH-1:0] rise_tick,
  output logic [N_CH-1:0] fall_tick,
  output logic [N_CH-1:0] repeat_tick
);

  localparam int CYCLES_PER_MS = CLK_FREQ / 1000;
  localparam int COUNT_CYCLES  = CYCLES_PER_MS * DEBOUNCE_TIME_MS;
  localparam int CNT_W         = $clog2(COUNT_CYCLES + 1);

  // Value loaded on entering a WAIT state: the exit check happens the cycle
  // the counter is already 0, so COUNT_CYCLES-1 gives COUNT_CYCLES wait edges.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COUNT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time sanity checks on the configuration.
  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("debounce_bank: N_CH must be in 1..32");
  end
  if (COUNT_CYCLES < 1) begin : g_bad_count
    $error("debounce_bank: debounce time must be at least one clock cycle");
  end
  if (HOLD_MS < 1 || REPEAT_MS < 1) begin : g_bad_repeat
    $error("debounce_bank: HOLD_MS and REPEAT_MS must be at least 1");
  end

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync_in;

  state_t           state [N_CH];
  logic [CNT_W-1:0] cnt   [N_CH];

  // Two-flop synchronizer bringing the asynchronous inputs into clk domain.
  // NOTE: sequential state is always written with non-blocking (<=) so every
  // flop samples pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_in   <= '0;
    end else begin
      sync_meta <= noisy_in;
      sync_in   <= sync_meta;
    end
  end

  // Per-channel debounce FSM with registered level and edge-tick outputs.
  // NOTE: the state/counter arrays are ordinary flops, not RAM, so they are
  // reset like any other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= ZERO;
        cnt[i]   <= '0;
      end
      clean_level <= '0;
      rise_tick   <= '0;
      fall_tick   <= '0;
    end else begin
      // Ticks are single-cycle: cleared every edge unless set below.
      rise_tick <= '0;
      fall_tick <= '0;
      for (int i = 0; i < N_CH; i++) begin
        case (state[i])
          ZERO: begin
            if (sync_in[i]) begin
              state[i] <= WAIT1;
              cnt[i]   <= CNT_LOAD;
            end
          end
          WAIT1: begin
            if (!sync_in[i]) begin
              state[i] <= ZERO;
            end else if (cnt[i] == '0) begin
              state[i]       <= ONE;
              clean_level[i] <= 1'b1;
              rise_tick[i]   <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] - CNT_ONE;
            end
          end
          ONE: begin
            if (!sync_in[i]) begin
              state[i] <= WAIT0;
              cnt[i]   <= CNT_LOAD;
            end
          end
          WAIT0: begin
            if (sync_in[i]) begin
              state[i] <= ONE;
            end else if (cnt[i] == '0) begin
              state[i]       <= ZERO;
              clean_level[i] <= 1'b0;
              fall_tick[i]   <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] - CNT_ONE;
            end
          end
          default: begin
            state[i] <= ZERO;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN

  localparam int HOLD_CYCLES   = CYCLES_PER_MS * HOLD_MS;
  localparam int REPEAT_CYCLES = CYCLES_PER_MS * REPEAT_MS;
  localparam int HOLD_MAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W        = $clog2(HOLD_MAX + 1);

  // Loads are one less than the period because the pulse fires on the edge
  // that finds the counter already at 0.
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LOAD = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  logic [N_CH-1:0]   enter_one;
  logic [HOLD_W-1:0] hold_cnt [N_CH];

  // Decode, per channel, the edges on which the FSM moves into ONE.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    enter_one = '0;
    for (int i = 0; i < N_CH; i++) begin
      enter_one[i] = sync_in[i] &&
                     ((state[i] == WAIT1 && cnt[i] == '0) || state[i] == WAIT0);
    end
  end

  // Hold/repeat timer: arm on entry to ONE, pulse after the hold time and
  // then at the repeat period while the channel stays in ONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        hold_cnt[i] <= '0;
      end
      repeat_tick <= '0;
    end else begin
      repeat_tick <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (state[i] == ONE && sync_in[i]) begin
          if (hold_cnt[i] == '0) begin
            repeat_tick[i] <= 1'b1;
            hold_cnt[i]    <= REPEAT_LOAD;
          end else begin
            hold_cnt[i] <= hold_cnt[i] - HOLD_ONE;
          end
        end else if (enter_one[i]) begin
          hold_cnt[i] <= HOLD_LOAD;
        end else begin
          hold_cnt[i] <= '0;
        end
      end
    end
  end

`else

  // Auto-repeat not built: the port stays for interface compatibility.
  assign repeat_tick = '0;

`endif

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed self-checking bench for debounce_bank with
// N_CH=4, CLK_FREQ=1000, DEBOUNCE_TIME_MS=4, HOLD_MS=10, REPEAT_MS=3
// (COUNT=4, HOLD=10, REPEAT=3 cycles). Inputs are driven and outputs are
// sampled on the falling edge; the negedge just after posedge E0+k is
// reached k+1 negedges after the drive point.

module tb_debounce_bank;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] noisy_in = 4'b0000;
  logic [3:0] clean_level;
  logic [3:0] rise_tick;
  logic [3:0] fall_tick;
  logic [3:0] repeat_tick;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;
  logic [3:0] seen;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam logic [3:0] REP3 = 4'b1000;
`else
  localparam logic [3:0] REP3 = 4'b0000;
`endif

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH             (4),
    .CLK_FREQ         (1000),
    .DEBOUNCE_TIME_MS (4),
    .HOLD_MS          (10),
    .REPEAT_MS        (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .noisy_in    (noisy_in),
    .clean_level (clean_level),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .repeat_tick (repeat_tick)
  );

  // Rise and fall of one channel must never coincide.
  always @(negedge clk) begin
    if (!reset && |(rise_tick & fall_tick)) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    reset    = 1'b1;
    noisy_in = 4'b0000;
    cyc(3);
    check("reset_clean",  clean_level, 4'b0000);
    check("reset_rise",   rise_tick,   4'b0000);
    check("reset_fall",   fall_tick,   4'b0000);
    check("reset_repeat", repeat_tick, 4'b0000);
    reset = 1'b0;
    cyc(3);

    // Channel 0 rises: clean_level moves after E0+6
    noisy_in = 4'b0001;
    cyc(6);
    check("t1_clean_early", clean_level, 4'b0000);
    check("t1_rise_early",  rise_tick,   4'b0000);
    cyc(1);
    check("t1_clean", clean_level, 4'b0001);
    check("t1_rise",  rise_tick,   4'b0001);
    check("t1_fall",  fall_tick,   4'b0000);
    cyc(1);
    check("t1_rise_end",  rise_tick,   4'b0000);
    check("t1_clean_hold", clean_level, 4'b0001);

    // Channel 1 glitch of 3 cycles: no tick
    noisy_in = 4'b0011;
    cyc(3);
    noisy_in = 4'b0001;
    seen = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      seen |= rise_tick | fall_tick;
    end
    check("t2_glitch_ticks", seen,        4'b0000);
    check("t2_glitch_clean", clean_level, 4'b0001);

    // Channel 1 held high: debounces
    noisy_in = 4'b0011;
    cyc(6);
    check("t2_clean_early", clean_level, 4'b0001);
    cyc(1);
    check("t2_rise",  rise_tick,   4'b0010);
    check("t2_clean", clean_level, 4'b0011);

    // All channels together
    noisy_in = 4'b0000;
    cyc(12);
    check("t3_cleared", clean_level, 4'b0000);
    noisy_in = 4'b1111;
    cyc(7);
    check("t3_rise_all", rise_tick,   4'b1111);
    check("t3_clean_all", clean_level, 4'b1111);
    check("t3_fall_none", fall_tick,   4'b0000);
    cyc(2);
    noisy_in = 4'b0000;
    cyc(7);
    check("t3_fall_all",  fall_tick,   4'b1111);
    check("t3_clean_low", clean_level, 4'b0000);
    check("t3_rise_none", rise_tick,   4'b0000);
    check("t3_repeat",    repeat_tick, 4'b0000);

    // Reset while channel 2 is in WAIT1 with counter at 1
    cyc(3);
    noisy_in = 4'b0100;
    cyc(5);
    check("t4_pre_reset_clean", clean_level, 4'b0000);
    reset = 1'b1;
    cyc(1);
    check("t4_outputs_zero", {clean_level, rise_tick, fall_tick, repeat_tick}, 16'h0000);
    reset = 1'b0;
    cyc(6);
    check("t4_rise_early",  rise_tick,   4'b0000);
    check("t4_clean_early", clean_level, 4'b0000);
    cyc(1);
    check("t4_rise",  rise_tick,   4'b0100);
    check("t4_clean", clean_level, 4'b0100);

    // Channel 3 held: auto-repeat at +10, then every 3 cycles
    noisy_in = 4'b0000;
    cyc(12);
    check("t5_cleared", clean_level, 4'b0000);
    noisy_in = 4'b1000;
    cyc(7);
    check("t5_rise",           rise_tick,   4'b1000);
    check("t5_repeat_at_rise", repeat_tick, 4'b0000);
    seen = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      seen |= repeat_tick;
    end
    check("t5_hold_quiet", seen, 4'b0000);
    cyc(1);
    check("t5_repeat_1", repeat_tick, REP3);
    seen = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      seen |= repeat_tick;
    end
    check("t5_gap_1", seen, 4'b0000);
    cyc(1);
    check("t5_repeat_2", repeat_tick, REP3);
    seen = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      seen |= repeat_tick;
    end
    check("t5_gap_2", seen, 4'b0000);
    noisy_in = 4'b0000;
    cyc(1);
    check("t5_repeat_3", repeat_tick, REP3);
    seen = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      seen |= repeat_tick;
    end
    check("t5_release_quiet", seen,        4'b0000);
    check("t5_fall",          fall_tick,   4'b1000);
    check("t5_clean_low",     clean_level, 4'b0000);
    seen = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      seen |= repeat_tick;
    end
    check("t5_after_quiet", seen, 4'b0000);

    check("rise_fall_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
